// File: rtl/l0_skew_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : l0_skew_fifo_if
// Purpose  : Write/launch handshake and skewed per-row outputs of the L0 buffer.
// Revision : 1.0
// ============================================================================
interface l0_skew_fifo_if #(
    parameter int ROW = 8,
    parameter int BW  = 4
);
    logic                wr;
    logic [ROW*BW-1:0]   in;
    logic                rd;
    logic [2:0]          inst_in;
    logic [ROW*BW-1:0]   out;
    logic [ROW*3-1:0]    out_inst;
    logic [ROW-1:0]      out_valid;
    logic                o_full;
    logic                o_ready;
    logic                o_empty;
    logic                o_underrun;

    modport master (
        output wr, in, rd, inst_in,
        input  out, out_inst, out_valid, o_full, o_ready, o_empty, o_underrun
    );

    modport slave (
        input  wr, in, rd, inst_in,
        output out, out_inst, out_valid, o_full, o_ready, o_empty, o_underrun
    );
endinterface
`default_nettype wire

// File: rtl/l0_skew_fifo.sv
`default_nettype none
// ============================================================================
// Module   : l0_skew_fifo
// Purpose  : Per-row input FIFOs for the mac_tile west edge, popped on a diagonal skew.
// Revision : 1.0
// ============================================================================
module l0_skew_fifo #(
    parameter int ROW   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64
) (
    input  wire logic         clk,
    input  wire logic         reset,
    l0_skew_fifo_if.slave     bus
);
    localparam int               c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_full_cnt = DEPTH[c_aw:0];

    logic             w_full;
    logic             w_empty;
    logic             w_launch;
    logic             w_wr_ok;
    logic [ROW-1:0]   w_rd_q;
    logic [2:0]       w_inst_q [ROW];
    logic [ROW-1:0]   w_starve;

    logic [ROW-1:1]   r_rd_q;
    logic [2:0]       r_inst_q [1:ROW-1];
    logic             r_underrun;

    assign w_wr_ok = bus.wr & ~w_full;

    // Row 0 acts on rd directly; deeper rows see the launch through a delay line.
    always_comb begin
        w_rd_q      = '0;
        w_rd_q[0]   = w_launch;
        w_inst_q[0] = bus.inst_in;
        for (int r = 1; r < ROW; r++) begin
            w_rd_q[r]   = r_rd_q[r];
            w_inst_q[r] = r_inst_q[r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_q <= '0;
            for (int r = 1; r < ROW; r++) begin
                r_inst_q[r] <= 3'b000;
            end
        end else begin
            for (int r = 1; r < ROW; r++) begin
                r_rd_q[r]   <= w_rd_q[r-1];
                r_inst_q[r] <= w_inst_q[r-1];
            end
        end
    end

    for (genvar r = 0; r < ROW; r++) begin : g_row
        logic [BW-1:0]   r_mem [DEPTH];
        logic [c_aw-1:0] r_wptr;
        logic [c_aw-1:0] r_rptr;
        logic [c_aw:0]   r_count;
        logic [BW-1:0]   r_out;
        logic [2:0]      r_out_inst;
        logic            r_valid;
        logic            w_pop;

        assign w_pop       = w_rd_q[r] & (r_count != '0);
        assign w_starve[r] = w_rd_q[r] & (r_count == '0);

        if (r == 0) begin : g_head
            assign w_full   = (r_count == c_full_cnt);
            assign w_launch = bus.rd & (r_count != '0);
        end

        if (r == ROW - 1) begin : g_last
            assign w_empty = (r_count == '0);
        end

        always_ff @(posedge clk) begin
            if (w_wr_ok) begin
                r_mem[r_wptr] <= bus.in[r*BW +: BW];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
                r_out      <= '0;
                r_out_inst <= 3'b000;
                r_valid    <= 1'b0;
            end else begin
                if (w_wr_ok) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr     <= r_rptr + 1'b1;
                    r_out      <= r_mem[r_rptr];
                    r_out_inst <= w_inst_q[r];
                    r_valid    <= 1'b1;
                end else begin
                    // Data holds; a zero instruction parks the tile.
                    r_out_inst <= 3'b000;
                    r_valid    <= 1'b0;
                end
                r_count <= r_count + {{c_aw{1'b0}}, w_wr_ok} - {{c_aw{1'b0}}, w_pop};
            end
        end

        assign bus.out[r*BW +: BW]     = r_out;
        assign bus.out_inst[r*3 +: 3]  = r_out_inst;
        assign bus.out_valid[r]        = r_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else if (|w_starve) begin
            r_underrun <= 1'b1;
        end
    end

    assign bus.o_full     = w_full;
    assign bus.o_ready    = ~w_full;
    assign bus.o_empty    = w_empty;
    assign bus.o_underrun = r_underrun;
endmodule
`default_nettype wire
